fetch_pc_ctrl: RTL

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/ifid_reg.sv | 46 ++++
 rtl/fetch_pc_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU front end.
//   - fetch_state_t : fetch controller state (RUN / HALT / ERR)
//   - HALT_INSTR_ENC: default halt encoding, beq x0,x0,0 (a branch to itself)
//   - OPC_*         : RV32I major opcodes, for decode stages that share this package
//   - pc_word_ok    : true when an address is word aligned and inside instruction memory
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_INSTR_ENC = 32'h0000_0063;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // pc_max is the highest legal word address (memory size minus 4).
  function automatic logic pc_word_ok(input logic [31:0] pc, input logic [31:0] pc_max);
    return (pc[1:0] == 2'b00) && (pc <= pc_max);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   CLK, Reset (async, active-low)
//   load      : capture d_instr/d_pc, set valid
//   flush     : clear valid only; payload holds (wins over load)
//   neither   : hold everything
//   valid/pc/pc4/instr : registered outputs, pc4 = pc + 4 computed at capture
module ifid_reg (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_instr;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
      r_instr <= 32'h0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_pc    <= d_pc;
      r_pc4   <= d_pc + 32'd4;
      r_instr <= d_instr;
    end
  end

  assign valid = r_valid;
  assign pc    = r_pc;
  assign pc4   = r_pc4;
  assign instr = r_instr;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: program counter and fetch state machine feeding the IF/ID register.
//   CLK, Reset (async, active-low)
//   instr_in    : instruction word at pc_out, valid before the next posedge
//   stall       : hold fetch (load-use)
//   redirect    : taken branch / jal, target on redirect_pc (beats stall)
//   pc_out      : current fetch address
//   id_valid/id_pc/id_pc4/id_instr : IF/ID register contents
//   halted      : state is not RUN
//   err         : sticky fault (bad redirect target or PC ran off the end of memory)
//   stall_cnt   : saturating count of stalled cycles
//   dbg_state   : raw fetch_state_t encoding
// Handshake: there is none; every input is sampled on each posedge, redirect has
// priority over stall, and stall has priority over the normal advance.
module fetch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_ENC
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic        err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_err, w_err_nxt;
  logic [15:0]  r_stall_cnt, w_stall_cnt_nxt;
  logic         w_load;
  logic         w_flush;
  logic [32:0]  w_pc_plus4;

  // 33 bits so that a PC near 2^32 cannot wrap past the range check.
  assign w_pc_plus4 = {1'b0, r_pc} + 33'd4;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_err_nxt       = r_err;
    w_stall_cnt_nxt = r_stall_cnt;
    w_load          = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      ST_RUN, ST_HALT: begin
        if (redirect) begin
          w_flush = 1'b1;
          if (pc_word_ok(redirect_pc, PC_MAX)) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_RUN;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end else if (r_state == ST_HALT) begin
          // The halt instruction was delivered on entry; drop it afterwards.
          w_flush = 1'b1;
        end else if (stall) begin
          if (r_stall_cnt != 16'hFFFF) w_stall_cnt_nxt = r_stall_cnt + 16'd1;
        end else begin
          w_load = 1'b1;
          // Running off the end of memory outranks a halt at the last word.
          if (w_pc_plus4 > {1'b0, PC_MAX}) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end else if (instr_in == HALT_INSTR) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt = w_pc_plus4[31:0];
          end
        end
      end
      ST_ERR: begin
        w_flush = 1'b1;
      end
      default: begin
        w_flush     = 1'b1;
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_RUN;
      r_pc        <= PC_RESET;
      r_err       <= 1'b0;
      r_stall_cnt <= 16'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_err       <= w_err_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  ifid_reg u_ifid (
    .CLK     (CLK),
    .Reset   (Reset),
    .load    (w_load),
    .flush   (w_flush),
    .d_instr (instr_in),
    .d_pc    (r_pc),
    .valid   (id_valid),
    .pc      (id_pc),
    .pc4     (id_pc4),
    .instr   (id_instr)
  );

  assign pc_out    = r_pc;
  assign halted    = (r_state != ST_RUN);
  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule
